// File: rtl/carregador_framebuffer_if.sv
// Pixel stream and framebuffer write-port bundle for carregador_framebuffer.
//   pixel_in/pixel_sof/pixel_valid : source -> loader, qualified by pixel_ready
//   pixel_ready                    : loader -> source, pixel accepted this cycle
//   linha/coluna/byte_entrada      : loader -> framebuffer, write address/data
//   escrever_na_matriz             : loader -> framebuffer, one-cycle write strobe
// master = pixel source / framebuffer side, slave = the loader.
interface carregador_framebuffer_if;
  logic [7:0] pixel_in;
  logic       pixel_sof;
  logic       pixel_valid;
  logic       pixel_ready;
  logic [7:0] linha;
  logic [8:0] coluna;
  logic       escrever_na_matriz;
  logic [7:0] byte_entrada;

  modport master (
    output pixel_in, pixel_sof, pixel_valid,
    input  pixel_ready, linha, coluna, escrever_na_matriz, byte_entrada
  );

  modport slave (
    input  pixel_in, pixel_sof, pixel_valid,
    output pixel_ready, linha, coluna, escrever_na_matriz, byte_entrada
  );
endinterface

// File: rtl/carregador_framebuffer.sv
// Write-side engine for the LARGURA x ALTURA 8-bit framebuffer. Accepts a
// raster-ordered pixel stream and turns it into framebuffer writes. In
// reduction mode the source is 2*LARGURA x 2*ALTURA and only even-row /
// even-column pixels are written.
// Ports:
//   clock, reset  : single clock, asynchronous active-high reset
//   start         : request to load a frame (ignored while loading)
//   modo_reducao  : 0 = native size source, 1 = 2x source decimated 2:1
//   fb            : pixel stream in / framebuffer write port out (slave side)
//   busy          : high while loading
//   frame_done    : one-cycle pulse after the final pixel is written
//   erro          : sticky framing error, cleared by reset or accepted start
module carregador_framebuffer #(
  parameter int LARGURA = 320,
  parameter int ALTURA  = 240
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     modo_reducao,
  carregador_framebuffer_if.slave  fb,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     erro
);

  typedef enum logic [1:0] {OCIOSO, CARREGANDO, CONCLUIDO} estado_t;

  localparam logic [9:0] W_NORMAL  = 10'(LARGURA - 1);
  localparam logic [9:0] W_REDUCAO = 10'(2 * LARGURA - 1);
  localparam logic [8:0] H_NORMAL  = 9'(ALTURA - 1);
  localparam logic [8:0] H_REDUCAO = 9'(2 * ALTURA - 1);

  estado_t    state_reg, state_next;
  logic [9:0] src_x_reg, src_x_next;
  logic [8:0] src_y_reg, src_y_next;
  logic       modo_reg, modo_next;
  logic       erro_reg, erro_next;
  logic       ready_reg, ready_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       esc_reg, esc_next;
  logic [7:0] linha_reg, linha_next;
  logic [8:0] coluna_reg, coluna_next;
  logic [7:0] byte_reg, byte_next;

  // Effective position of the pixel being accepted (after SOF resync).
  logic [9:0] eff_x;
  logic [8:0] eff_y;
  logic [9:0] w_lim;
  logic [8:0] h_lim;
  logic       accept;
  logic       first;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= OCIOSO;
      src_x_reg  <= '0;
      src_y_reg  <= '0;
      modo_reg   <= 1'b0;
      erro_reg   <= 1'b0;
      ready_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      esc_reg    <= 1'b0;
      linha_reg  <= '0;
      coluna_reg <= '0;
      byte_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      src_x_reg  <= src_x_next;
      src_y_reg  <= src_y_next;
      modo_reg   <= modo_next;
      erro_reg   <= erro_next;
      ready_reg  <= ready_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      esc_reg    <= esc_next;
      linha_reg  <= linha_next;
      coluna_reg <= coluna_next;
      byte_reg   <= byte_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    src_x_next  = src_x_reg;
    src_y_next  = src_y_reg;
    modo_next   = modo_reg;
    erro_next   = erro_reg;
    esc_next    = 1'b0;
    linha_next  = linha_reg;
    coluna_next = coluna_reg;
    byte_next   = byte_reg;
    eff_x       = src_x_reg;
    eff_y       = src_y_reg;
    w_lim       = modo_reg ? W_REDUCAO : W_NORMAL;
    h_lim       = modo_reg ? H_REDUCAO : H_NORMAL;
    // ready_reg is high exactly while in CARREGANDO
    accept      = fb.pixel_valid && ready_reg;
    first       = (src_x_reg == '0) && (src_y_reg == '0);

    case (state_reg)
      OCIOSO, CONCLUIDO: begin
        if (start) begin
          state_next = CARREGANDO;
          modo_next  = modo_reducao;
          src_x_next = '0;
          src_y_next = '0;
          erro_next  = 1'b0;
        end else if (state_reg == CONCLUIDO) begin
          state_next = OCIOSO;
        end
      end
      CARREGANDO: begin
        if (accept) begin
          // A misplaced SOF restarts the raster at (0,0); a missing SOF on
          // the first pixel is only flagged.
          if (fb.pixel_sof && !first) begin
            erro_next = 1'b1;
            eff_x     = '0;
            eff_y     = '0;
          end else if (!fb.pixel_sof && first) begin
            erro_next = 1'b1;
          end

          if (!modo_reg || (!eff_x[0] && !eff_y[0])) begin
            esc_next = 1'b1;
          end
          linha_next  = modo_reg ? eff_y[8:1] : eff_y[7:0];
          coluna_next = modo_reg ? eff_x[9:1] : eff_x[8:0];
          byte_next   = fb.pixel_in;

          if (eff_x == w_lim) begin
            src_x_next = '0;
            src_y_next = eff_y + 9'd1;
            if (eff_y == h_lim) begin
              state_next = CONCLUIDO;
            end
          end else begin
            src_x_next = eff_x + 10'd1;
            src_y_next = eff_y;
          end
        end
      end
      default: state_next = OCIOSO;
    endcase

    // Status outputs are registered copies of the next state so they line
    // up with the final write strobe.
    ready_next = (state_next == CARREGANDO);
    busy_next  = (state_next == CARREGANDO);
    done_next  = (state_next == CONCLUIDO);
  end

  assign fb.pixel_ready        = ready_reg;
  assign fb.escrever_na_matriz = esc_reg;
  assign fb.linha              = linha_reg;
  assign fb.coluna             = coluna_reg;
  assign fb.byte_entrada       = byte_reg;
  assign busy                  = busy_reg;
  assign frame_done            = done_reg;
  assign erro                  = erro_reg;

endmodule

// File: tb/tb_carregador_framebuffer.sv
// Directed bench for carregador_framebuffer on a reduced 16x4 buffer.
module tb_carregador_framebuffer;
  localparam int L = 16;
  localparam int A = 4;

  logic clock;
  logic reset;
  logic start;
  logic modo_reducao;
  logic busy;
  logic frame_done;
  logic erro;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  carregador_framebuffer_if fb_if ();

  carregador_framebuffer #(.LARGURA(L), .ALTURA(A)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .modo_reducao (modo_reducao),
    .fb           (fb_if),
    .busy         (busy),
    .frame_done   (frame_done),
    .erro         (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " pixel_ready"}, fb_if.pixel_ready, 0);
    chk({tag, " linha"}, fb_if.linha, 0);
    chk({tag, " coluna"}, fb_if.coluna, 0);
    chk({tag, " strobe"}, fb_if.escrever_na_matriz, 0);
    chk({tag, " byte"}, fb_if.byte_entrada, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " erro"}, erro, 0);
  endtask

  // One clock of stimulus while loading; checks the write caused by it.
  task automatic step(input bit v, input logic [7:0] pix, input bit sof, input bit st,
                      input bit exp_w, input int exp_l, input int exp_c);
    fb_if.pixel_valid = v;
    fb_if.pixel_in    = pix;
    fb_if.pixel_sof   = sof;
    start             = st;
    chk("pixel_ready", fb_if.pixel_ready, 1);
    @(posedge clock);
    #1;
    chk("strobe", fb_if.escrever_na_matriz, exp_w);
    if (fb_if.escrever_na_matriz === 1'b1) strobes++;
    if (exp_w) begin
      chk("linha", fb_if.linha, exp_l);
      chk("coluna", fb_if.coluna, exp_c);
      chk("byte", fb_if.byte_entrada, pix);
    end
    fb_if.pixel_valid = 1'b0;
    fb_if.pixel_sof   = 1'b0;
    start             = 1'b0;
  endtask

  task automatic do_start(input bit mode);
    start        = 1'b1;
    modo_reducao = mode;
    @(posedge clock);
    #1;
    start        = 1'b0;
    modo_reducao = 1'b0;
    chk("start busy", busy, 1);
    chk("start ready", fb_if.pixel_ready, 1);
    chk("start erro", erro, 0);
    strobes = 0;
  endtask

  task automatic check_end(input int exp_strobes, input bit exp_erro);
    chk("end frame_done", frame_done, 1);
    chk("end busy", busy, 0);
    chk("end ready", fb_if.pixel_ready, 0);
    chk("end erro", erro, exp_erro);
    chk("end strobes", strobes, exp_strobes);
    @(posedge clock);
    #1;
    chk("after frame_done", frame_done, 0);
    chk("after strobe", fb_if.escrever_na_matriz, 0);
    chk("after ready", fb_if.pixel_ready, 0);
  endtask

  task automatic run_frame(input bit mode, input bit gaps, input int start_at);
    int wl, hl, n;
    bit w;
    wl = mode ? 2 * L : L;
    hl = mode ? 2 * A : A;
    n  = 0;
    do_start(mode);
    for (int y = 0; y < hl; y++) begin
      for (int x = 0; x < wl; x++) begin
        if (gaps) begin
          while ($urandom_range(0, 9) < 3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        end
        w = !mode || ((x % 2 == 0) && (y % 2 == 0));
        step(1'b1, 8'((x + y) & 255), n == 0, n == start_at, w,
             mode ? y / 2 : y, mode ? x / 2 : x);
        n++;
      end
    end
    check_end(L * A, 1'b0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset             = 1'b0;
    start             = 1'b0;
    modo_reducao      = 1'b0;
    fb_if.pixel_valid = 1'b0;
    fb_if.pixel_sof   = 1'b0;
    fb_if.pixel_in    = 8'h00;
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("reset");
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    chk_reset_outputs("idle");

    // Normal frame; last write at (3,15) with data 15+3 = 0x12.
    run_frame(1'b0, 1'b0, -1);
    chk("last linha", fb_if.linha, 3);
    chk("last coluna", fb_if.coluna, 15);
    chk("last byte", fb_if.byte_entrada, 8'h12);

    // Reduction frame: 32x8 source, 64 writes.
    run_frame(1'b1, 1'b0, -1);

    // Normal frame with random valid gaps.
    run_frame(1'b0, 1'b1, -1);

    // start pulsed mid-frame must not restart the raster.
    run_frame(1'b0, 1'b0, 10);

    // Misplaced SOF at (5,0): written at (0,0), then continue from (1,0).
    do_start(1'b0);
    for (int x = 0; x < 5; x++) step(1'b1, 8'(x), x == 0, 1'b0, 1'b1, 0, x);
    chk("erro before sof", erro, 0);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 0, 0);
    chk("erro after sof", erro, 1);
    for (int y = 0; y < A; y++) begin
      for (int x = (y == 0) ? 1 : 0; x < L; x++) begin
        step(1'b1, 8'((x + y) & 255), 1'b0, 1'b0, 1'b1, y, x);
      end
    end
    check_end(5 + L * A, 1'b1);
    do_start(1'b0);

    // Missing SOF on first pixel, then reset mid-frame with a strobe in flight.
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("erro missing sof", erro, 1);
    for (int x = 1; x < 12; x++) step(1'b1, 8'(x), 1'b0, 1'b0, 1'b1, 0, x);
    chk("inflight strobe", fb_if.escrever_na_matriz, 1);
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clock);
    #1 reset = 1'b0;
    chk_reset_outputs("post reset");

    // Fresh frame after the reset starts again at (0,0).
    run_frame(1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
